// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the two-master AXI read arbiter.
// Build option: AXI_DEFAULT_SLAVE_EN enables the DECERR default slave.
package axi_arb_pkg;

  localparam int IDM_W  = 4;
  localparam int IDS_W  = IDM_W + 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 4;

  localparam logic [15:0] S0_BASE = 16'h0000;
  localparam logic [15:0] S1_BASE = 16'h0001;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef struct packed {
    logic [IDM_W-1:0]  id;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic [2:0]        size;
    logic [1:0]        burst;
  } ar_req_t;

  typedef struct packed {
    logic [IDS_W-1:0]  id;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic [2:0]        size;
    logic [1:0]        burst;
  } ar_req_s_t;

  typedef struct packed {
    logic [IDM_W-1:0]  id;
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
    logic              last;
  } r_rsp_t;

  typedef struct packed {
    logic [IDS_W-1:0]  id;
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
    logic              last;
  } r_rsp_s_t;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    DERR
  } state_e;

  function automatic logic dec_s1(input logic [15:0] hi);
    return hi == S1_BASE;
  endfunction

  function automatic logic dec_unmapped(input logic [15:0] hi);
    return (hi != S0_BASE) && (hi != S1_BASE);
  endfunction

endpackage

// File: rtl/axi_rr_arb2.sv
// Two-way round-robin picker; one-hot grant, the side that
// did not win last time is preferred when both request.
module axi_rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic [1:0] o_gnt
);

  always_comb begin
    if (&i_req) o_gnt = i_last ? 2'b01 : 2'b10;
    else        o_gnt = i_req;
  end

endmodule

// File: rtl/axi_read_arbiter.sv
// Single-outstanding AXI read arbiter: two masters onto two slaves.
// Build option: AXI_DEFAULT_SLAVE_EN routes unmapped reads to DECERR.
module axi_read_arbiter
  import axi_arb_pkg::*;
(
  input  logic                ACLK,
  input  logic                ARESETn,
  input  logic [1:0]          m_ar_valid,
  input  ar_req_t   [1:0]     m_ar,
  output logic [1:0]          m_ar_ready,
  output logic [1:0]          m_r_valid,
  output r_rsp_t              m_r,
  input  logic [1:0]          m_r_ready,
  output logic [1:0]          s_ar_valid,
  output ar_req_s_t           s_ar,
  input  logic [1:0]          s_ar_ready,
  input  logic [1:0]          s_r_valid,
  input  r_rsp_s_t  [1:0]     s_r,
  output logic [1:0]          s_r_ready
);

  state_e     r_state;
  state_e     w_next;
  logic       r_grant;
  logic       r_last;
  logic       r_sel;
  logic [1:0] w_gnt_oh;
  logic       w_gnt;
  logic [15:0] w_hi;
  ar_req_t    w_ar;
  r_rsp_s_t   w_sr;
  logic       w_r_hs;
  logic       w_unused_rid;

`ifdef AXI_DEFAULT_SLAVE_EN
  logic             r_unmap;
  logic [LEN_W-1:0] r_beat_cnt;
  logic [LEN_W-1:0] r_len;
  logic [IDM_W-1:0] r_id;
`endif

  axi_rr_arb2 u_rr (
    .i_req  (m_ar_valid),
    .i_last (r_last),
    .o_gnt  (w_gnt_oh)
  );

  assign w_gnt = w_gnt_oh[1];
  assign w_hi  = m_ar[w_gnt].addr[ADDR_W-1:16];
  assign w_ar  = m_ar[r_grant];
  assign w_sr  = s_r[r_sel];

  // Upper slave-ID bits only carry the routing tag and are dropped.
  assign w_unused_rid = ^{s_r[0].id[IDS_W-1:IDM_W],
                          s_r[1].id[IDS_W-1:IDM_W]};

  always_comb begin
    w_next     = r_state;
    m_ar_ready = '0;
    m_r_valid  = '0;
    m_r        = '0;
    s_ar_valid = '0;
    s_ar       = '0;
    s_r_ready  = '0;
    w_r_hs     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (|w_gnt_oh) w_next = ADDR;
      end
      ADDR: begin
`ifdef AXI_DEFAULT_SLAVE_EN
        if (r_unmap) begin
          m_ar_ready[r_grant] = 1'b1;
          w_next = DERR;
        end else
`endif
        begin
          s_ar_valid[r_sel] = m_ar_valid[r_grant];
          s_ar.id    = {4'b0001 << r_grant, w_ar.id};
          s_ar.addr  = w_ar.addr;
          s_ar.len   = w_ar.len;
          s_ar.size  = w_ar.size;
          s_ar.burst = w_ar.burst;
          m_ar_ready[r_grant] = s_ar_ready[r_sel];
          if (m_ar_valid[r_grant] && s_ar_ready[r_sel])
            w_next = DATA;
        end
      end
      DATA: begin
        m_r_valid[r_grant] = s_r_valid[r_sel];
        m_r.id   = w_sr.id[IDM_W-1:0];
        m_r.data = w_sr.data;
        m_r.resp = w_sr.resp;
        m_r.last = w_sr.last;
        s_r_ready[r_sel] = m_r_ready[r_grant];
        w_r_hs = s_r_valid[r_sel] && m_r_ready[r_grant];
        if (w_r_hs && w_sr.last) w_next = IDLE;
      end
`ifdef AXI_DEFAULT_SLAVE_EN
      DERR: begin
        m_r_valid[r_grant] = 1'b1;
        m_r.id   = r_id;
        m_r.resp = RESP_DECERR;
        m_r.last = (r_beat_cnt == r_len);
        w_r_hs = m_r_ready[r_grant];
        if (w_r_hs && m_r.last) w_next = IDLE;
      end
`endif
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_state <= IDLE;
      r_grant <= 1'b0;
      r_last  <= 1'b1;
      r_sel   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && |w_gnt_oh) begin
        r_grant <= w_gnt;
        r_sel   <= dec_s1(w_hi);
      end
      if (r_state != IDLE && r_state != ADDR && w_next == IDLE)
        r_last <= r_grant;
    end
  end

`ifdef AXI_DEFAULT_SLAVE_EN
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_unmap    <= 1'b0;
      r_beat_cnt <= '0;
      r_len      <= '0;
      r_id       <= '0;
    end else begin
      if (r_state == IDLE && |w_gnt_oh)
        r_unmap <= dec_unmapped(w_hi);
      if (r_state == ADDR) begin
        r_beat_cnt <= '0;
        r_len      <= w_ar.len;
        r_id       <= w_ar.id;
      end else if (w_r_hs) begin
        r_beat_cnt <= r_beat_cnt + 1'b1;
      end
    end
  end
`endif

  a_ar_hold: assert property (@(posedge ACLK) disable iff (!ARESETn)
    (r_state == ADDR) |-> m_ar_valid[r_grant]);

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter; expected values are hand-derived.
// Build option: AXI_DEFAULT_SLAVE_EN selects the DECERR expectations.
module tb_axi_read_arbiter;
  import axi_arb_pkg::*;

  logic            ACLK;
  logic            ARESETn;
  logic [1:0]      m_ar_valid;
  ar_req_t [1:0]   m_ar;
  logic [1:0]      m_ar_ready;
  logic [1:0]      m_r_valid;
  r_rsp_t          m_r;
  logic [1:0]      m_r_ready;
  logic [1:0]      s_ar_valid;
  ar_req_s_t       s_ar;
  logic [1:0]      s_ar_ready;
  logic [1:0]      s_r_valid;
  r_rsp_s_t [1:0]  s_r;
  logic [1:0]      s_r_ready;

  int n_vec = 0;
  int n_err = 0;

  axi_read_arbiter dut (
    .ACLK       (ACLK),
    .ARESETn    (ARESETn),
    .m_ar_valid (m_ar_valid),
    .m_ar       (m_ar),
    .m_ar_ready (m_ar_ready),
    .m_r_valid  (m_r_valid),
    .m_r        (m_r),
    .m_r_ready  (m_r_ready),
    .s_ar_valid (s_ar_valid),
    .s_ar       (s_ar),
    .s_ar_ready (s_ar_ready),
    .s_r_valid  (s_r_valid),
    .s_r        (s_r),
    .s_r_ready  (s_r_ready)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic mid();
    @(negedge ACLK);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_arrdy"}, 64'(m_ar_ready), 64'd0);
    chk({tag, "_rvld"},  64'(m_r_valid),  64'd0);
    chk({tag, "_sarv"},  64'(s_ar_valid), 64'd0);
    chk({tag, "_srrdy"}, 64'(s_r_ready),  64'd0);
  endtask

  task automatic set_ar(input int m, input logic [3:0] id,
                        input logic [31:0] addr, input logic [3:0] len);
    m_ar[m].id    = id;
    m_ar[m].addr  = addr;
    m_ar[m].len   = len;
    m_ar[m].size  = 3'd2;
    m_ar[m].burst = 2'b01;
    m_ar_valid[m] = 1'b1;
  endtask

  // Called just after an edge that left the DUT in IDLE with requests set.
  task automatic run_ar(input int g, input int s, input logic [3:0] id,
                        input logic [31:0] addr, input logic [3:0] len);
    logic [3:0] tag;
    tag = (g == 0) ? 4'b0001 : 4'b0010;
    mid();
    chk("idle_arrdy", 64'(m_ar_ready), 64'd0);
    chk("idle_sarv",  64'(s_ar_valid), 64'd0);
    tick();
    s_ar_ready = 2'b11;
    mid();
    chk("addr_sarv",  64'(s_ar_valid), 64'(2'b01 << s));
    chk("addr_sid",   64'(s_ar.id),    64'({tag, id}));
    chk("addr_saddr", 64'(s_ar.addr),  64'(addr));
    chk("addr_slen",  64'(s_ar.len),   64'(len));
    chk("addr_arrdy", 64'(m_ar_ready), 64'(2'b01 << g));
    tick();
    m_ar_valid[g] = 1'b0;
    s_ar_ready = 2'b00;
  endtask

  task automatic run_r(input int g, input int s, input logic [3:0] id,
                       input int len, input logic [31:0] base,
                       input int stall_b, input int stall_n);
    logic [3:0] tag;
    tag = (g == 0) ? 4'b0001 : 4'b0010;
    for (int b = 0; b <= len; b++) begin
      s_r_valid     = 2'b01 << s;
      s_r[s].id     = {tag, id};
      s_r[s].data   = base + 32'(b);
      s_r[s].resp   = RESP_OKAY;
      s_r[s].last   = (b == len);
      if (b == stall_b) begin
        m_r_ready = 2'b00;
        for (int k = 0; k < stall_n; k++) begin
          mid();
          chk("stall_srrdy", 64'(s_r_ready), 64'd0);
          chk("stall_rvld",  64'(m_r_valid), 64'(2'b01 << g));
          chk("stall_data",  64'(m_r.data),  64'(base + 32'(b)));
          tick();
        end
      end
      m_r_ready = 2'b01 << g;
      mid();
      chk("beat_rvld",  64'(m_r_valid), 64'(2'b01 << g));
      chk("beat_data",  64'(m_r.data),  64'(base + 32'(b)));
      chk("beat_id",    64'(m_r.id),    64'(id));
      chk("beat_last",  64'(m_r.last),  64'(b == len));
      chk("beat_srrdy", 64'(s_r_ready), 64'(2'b01 << s));
      tick();
    end
    s_r_valid = 2'b00;
    m_r_ready = 2'b00;
  endtask

  initial begin
    ARESETn    = 1'b0;
    m_ar_valid = '0;
    m_ar       = '0;
    m_r_ready  = '0;
    s_ar_ready = '0;
    s_r_valid  = '0;
    s_r        = '0;
    tick();
    tick();
    mid();
    chk_quiet("rst");
    chk("rst_mr",  64'(m_r),  64'd0);
    chk("rst_sar", 64'(s_ar), 64'd0);
    tick();
    ARESETn = 1'b1;

    // M0 alone, 4-beat burst to S0
    set_ar(0, 4'h5, 32'h0000_0010, 4'd3);
    run_ar(0, 0, 4'h5, 32'h0000_0010, 4'd3);
    run_r(0, 0, 4'h5, 3, 32'hA000_0000, -1, 0);
    mid();
    chk_quiet("t1_done");

    // stray slave RVALID while idle
    tick();
    s_r_valid = 2'b10;
    s_r[1].last = 1'b1;
    mid();
    chk_quiet("t6_a");
    tick();
    mid();
    chk_quiet("t6_b");
    tick();
    s_r_valid = 2'b00;

    // M1 alone to S1, RREADY low for 5 cycles on beat 2
    set_ar(1, 4'h9, 32'h0001_0100, 4'd3);
    run_ar(1, 1, 4'h9, 32'h0001_0100, 4'd3);
    run_r(1, 1, 4'h9, 3, 32'hB000_0000, 2, 5);

    // both request; M1 was last so M0 first, then pending M1 beats M0
    set_ar(0, 4'h1, 32'h0001_0000, 4'd1);
    set_ar(1, 4'h2, 32'h0001_0040, 4'd0);
    run_ar(0, 1, 4'h1, 32'h0001_0000, 4'd1);
    run_r(0, 1, 4'h1, 1, 32'hC000_0000, -1, 0);
    set_ar(0, 4'h3, 32'h0000_0020, 4'd0);
    run_ar(1, 1, 4'h2, 32'h0001_0040, 4'd0);
    run_r(1, 1, 4'h2, 0, 32'hC100_0000, -1, 0);
    run_ar(0, 0, 4'h3, 32'h0000_0020, 4'd0);
    run_r(0, 0, 4'h3, 0, 32'hC200_0000, -1, 0);

    // unmapped address
    set_ar(0, 4'h7, 32'h0002_0000, 4'd1);
`ifdef AXI_DEFAULT_SLAVE_EN
    mid();
    chk("derr_idle", 64'(m_ar_ready), 64'd0);
    tick();
    mid();
    chk("derr_sarv",  64'(s_ar_valid), 64'd0);
    chk("derr_arrdy", 64'(m_ar_ready), 64'b01);
    tick();
    m_ar_valid = 2'b00;
    m_r_ready  = 2'b01;
    for (int b = 0; b < 2; b++) begin
      mid();
      chk("derr_rvld", 64'(m_r_valid), 64'b01);
      chk("derr_resp", 64'(m_r.resp),  64'(2'b11));
      chk("derr_data", 64'(m_r.data),  64'd0);
      chk("derr_id",   64'(m_r.id),    64'h7);
      chk("derr_last", 64'(m_r.last),  64'(b == 1));
      tick();
    end
    m_r_ready = 2'b00;
    mid();
    chk_quiet("derr_done");
    tick();
`else
    run_ar(0, 0, 4'h7, 32'h0002_0000, 4'd1);
    run_r(0, 0, 4'h7, 1, 32'hE000_0000, -1, 0);
`endif

    // reset during beat 2; last_grant returns to M1
    set_ar(0, 4'h4, 32'h0000_0010, 4'd3);
    run_ar(0, 0, 4'h4, 32'h0000_0010, 4'd3);
    s_r_valid   = 2'b01;
    s_r[0].id   = 8'h14;
    s_r[0].data = 32'hF000_0000;
    s_r[0].last = 1'b0;
    m_r_ready   = 2'b01;
    mid();
    chk("t5_b1", 64'(m_r.data), 64'hF000_0000);
    tick();
    s_r[0].data = 32'hF000_0001;
    ARESETn = 1'b0;
    tick();
    ARESETn = 1'b1;
    mid();
    chk_quiet("t5_rst");
    tick();
    mid();
    chk_quiet("t5_after");
    tick();
    s_r_valid = 2'b00;
    m_r_ready = 2'b00;
    set_ar(0, 4'h6, 32'h0001_0000, 4'd0);
    set_ar(1, 4'h8, 32'h0000_0000, 4'd0);
    run_ar(0, 1, 4'h6, 32'h0001_0000, 4'd0);
    run_r(0, 1, 4'h6, 0, 32'h1234_0000, -1, 0);
    run_ar(1, 0, 4'h8, 32'h0000_0000, 4'd0);
    run_r(1, 0, 4'h8, 0, 32'h5678_0000, -1, 0);
    mid();
    chk_quiet("end");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
